// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding, default index width and MC_LATENCY bounds for the hazard controller.
package hazard_ctrl_pkg;
    typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;
    localparam int REG_AW_DEFAULT = 5;
    localparam int MC_LATENCY_MIN = 2;
    localparam int MC_LATENCY_MAX = 15;
    function automatic bit mc_latency_ok(input int lat);
        return lat >= MC_LATENCY_MIN && lat <= MC_LATENCY_MAX;
    endfunction
endpackage

// File: rtl/mc_latency_counter.sv
// mc_latency_counter: down-counter for the remaining hold cycles of a multi-cycle EX op.
module mc_latency_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic         clear,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/hold/bubble/flush sequencer around EX (branch > multi-cycle > load-use).
// Define HAZARD_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int REG_AW     = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mc_op,
    input  logic              mem_branch,
    input  logic              mem_zero,
    output logic              pc_write,
    output logic              pc_src,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_flush,
    output logic              ex_mem_bubble,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              mc_busy
);
    localparam int CW = $clog2(MC_LATENCY);

    if (!mc_latency_ok(MC_LATENCY)) begin : g_bad_latency
        $error("MC_LATENCY out of range 2..15");
    end

    state_t state, state_n;
    logic   taken, load_use, freeze, cnt_zero, cnt_load, cnt_dec, cnt_clear;

    mc_latency_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .clear    (cnt_clear),
        .load_val (CW'(MC_LATENCY - 2)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_clear = 1'b0;
        taken     = mem_branch & mem_zero;
        load_use  = state == RUN && ex_memread && ex_rd != '0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        // the release cycle (MC_BUSY with count 0) drops out of freeze so the result reaches EX/MEM
        freeze    = state == RUN ? ex_mc_op : !cnt_zero;
        if (taken) begin
            state_n   = RUN;
            cnt_clear = 1'b1;
        end else if (state == RUN) begin
            state_n  = ex_mc_op ? MC_BUSY : RUN;
            cnt_load = ex_mc_op;
        end else begin
            state_n = cnt_zero ? RUN : MC_BUSY;
            cnt_dec = !cnt_zero;
        end
        pc_write      = taken || !(freeze || load_use);
        if_id_write   = taken || !(freeze || load_use);
        pc_src        = taken;
        if_id_flush   = taken;
        id_ex_flush   = taken || (!freeze && load_use);
        id_ex_hold    = !taken && freeze;
        ex_mem_bubble = !taken && freeze;
        mc_busy       = !taken && freeze;
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (taken && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule
